// File: rtl/adc_sampler.sv
// Serial-ADC front end: periodic SPI-style conversion frame, 10-bit sample extract, queue push with overrun flag.
// Optional ADC_SAMPLER_AVG_EN: push the truncated mean of four consecutive frames instead of every frame.
module adc_sampler #(
    parameter int SAMPLE_DIV = 1000,
    parameter int LEAD_BITS  = 3,
    parameter int FRAME_BITS = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [9:0] pre_i,
    input  logic       clr_ovr_i,
    input  logic       adc_miso_i,
    output logic       adc_sclk_o,
    output logic       adc_cs_n_o,
    output logic [9:0] out_data_o,
    output logic       ld_o,
    input  logic       full_i,
    output logic       overrun_o
);

    localparam int            EW       = $clog2(2 * FRAME_BITS);
    localparam logic [EW-1:0] LAST_HALF = EW'(2 * FRAME_BITS - 1);
    localparam logic [EW-1:0] BIT_LO    = EW'(LEAD_BITS);
    localparam logic [EW-1:0] BIT_HI    = EW'(LEAD_BITS + 10);
    localparam logic [15:0]   DIV_M1    = 16'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {IDLE, WAIT, CONV, PUSH} state_t;

    state_t        state_q, state_d;
    logic [15:0]   icnt_q, icnt_d;
    logic          pend_q, pend_d;
    logic [9:0]    pre_q, pre_d;
    logic [9:0]    hcnt_q, hcnt_d;
    logic [EW-1:0] ecnt_q, ecnt_d;
    logic          sclk_q, sclk_d;
    logic [9:0]    shreg_q, shreg_d;
    logic          ld_q, ld_d;
    logic [9:0]    data_q, data_d;
    logic          ovr_q, ovr_d;
    logic          start, ovr_set, expired;
    logic [EW-1:0] kidx;
    logic [9:0]    push_val;
`ifdef ADC_SAMPLER_AVG_EN
    logic [11:0]   acc_q, acc_d;
    logic [1:0]    fcnt_q, fcnt_d;
    logic [11:0]   sum;
`endif

    assign kidx    = {1'b0, ecnt_q[EW-1:1]};
    // Expiry is remembered so a frame overrunning the interval still starts the next one promptly.
    assign expired = pend_q || (icnt_q == DIV_M1);

`ifdef ADC_SAMPLER_AVG_EN
    assign sum      = acc_q + {2'b00, shreg_q};
    assign push_val = sum[11:2];
`else
    assign push_val = shreg_q;
`endif

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q + 16'd1;
        pend_d  = pend_q || (icnt_q == DIV_M1);
        pre_d   = pre_q;
        hcnt_d  = hcnt_q;
        ecnt_d  = ecnt_q;
        sclk_d  = sclk_q;
        shreg_d = shreg_q;
        ld_d    = 1'b0;
        data_d  = data_q;
        start   = 1'b0;
        ovr_set = 1'b0;
`ifdef ADC_SAMPLER_AVG_EN
        acc_d   = acc_q;
        fcnt_d  = fcnt_q;
`endif
        case (state_q)
            IDLE: begin
                icnt_d = 16'd0;
                pend_d = 1'b0;
`ifdef ADC_SAMPLER_AVG_EN
                acc_d  = 12'd0;
                fcnt_d = 2'd0;
`endif
                start  = en_i;
            end
            WAIT: begin
                if (!en_i)
                    state_d = IDLE;
                else
                    start = expired;
            end
            CONV: begin
                if (!en_i) begin
                    state_d = IDLE;
                    sclk_d  = 1'b0;
`ifdef ADC_SAMPLER_AVG_EN
                    acc_d   = 12'd0;
                    fcnt_d  = 2'd0;
`endif
                end else if (hcnt_q == pre_q) begin
                    hcnt_d = 10'd0;
                    sclk_d = ~sclk_q;
                    ecnt_d = ecnt_q + 1'b1;
                    if (!sclk_q && kidx >= BIT_LO && kidx < BIT_HI)
                        shreg_d = {shreg_q[8:0], adc_miso_i};
                    if (ecnt_q == LAST_HALF) begin
`ifdef ADC_SAMPLER_AVG_EN
                        if (fcnt_q == 2'd3) begin
                            state_d = PUSH;
                        end else begin
                            state_d = WAIT;
                            acc_d   = sum;
                            fcnt_d  = fcnt_q + 2'd1;
                        end
`else
                        state_d = PUSH;
`endif
                    end
                end else begin
                    hcnt_d = hcnt_q + 10'd1;
                end
            end
            PUSH: begin
                if (full_i) begin
                    ovr_set = 1'b1;
                end else begin
                    ld_d   = 1'b1;
                    data_d = push_val;
                end
`ifdef ADC_SAMPLER_AVG_EN
                acc_d  = 12'd0;
                fcnt_d = 2'd0;
`endif
                if (!en_i)
                    state_d = IDLE;
                else if (expired)
                    start = 1'b1;
                else
                    state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = CONV;
            icnt_d  = 16'd0;
            pend_d  = 1'b0;
            pre_d   = pre_i;
            hcnt_d  = 10'd0;
            ecnt_d  = '0;
            sclk_d  = 1'b0;
            shreg_d = 10'd0;
        end

        // A drop in the same cycle as a clear must stay visible.
        if (ovr_set)
            ovr_d = 1'b1;
        else if (clr_ovr_i)
            ovr_d = 1'b0;
        else
            ovr_d = ovr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            icnt_q  <= 16'd0;
            pend_q  <= 1'b0;
            pre_q   <= 10'd0;
            hcnt_q  <= 10'd0;
            ecnt_q  <= '0;
            sclk_q  <= 1'b0;
            shreg_q <= 10'd0;
            ld_q    <= 1'b0;
            data_q  <= 10'd0;
            ovr_q   <= 1'b0;
`ifdef ADC_SAMPLER_AVG_EN
            acc_q   <= 12'd0;
            fcnt_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            pend_q  <= pend_d;
            pre_q   <= pre_d;
            hcnt_q  <= hcnt_d;
            ecnt_q  <= ecnt_d;
            sclk_q  <= sclk_d;
            shreg_q <= shreg_d;
            ld_q    <= ld_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
`ifdef ADC_SAMPLER_AVG_EN
            acc_q   <= acc_d;
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    assign adc_cs_n_o = (state_q != CONV);
    assign adc_sclk_o = sclk_q;
    assign ld_o       = ld_q;
    assign out_data_o = data_q;
    assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler with a behavioural SPI ADC returning adc_word in each frame.
module tb_adc_sampler;

    logic       clk = 1'b0;
    logic       rst, en, clr, full;
    logic [9:0] pre;
    logic       adc_miso, adc_sclk, adc_cs_n, ld, overrun;
    logic [9:0] out_data;
    logic [9:0] adc_word;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int cs_low_cnt = 0, rise_cnt = 0, ld_cnt = 0;
    int fall_last = -1, fall_prev = -1, ld_cyc = -1;
    logic [9:0] ld_dat = 10'd0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0;

    adc_sampler #(.SAMPLE_DIV(300), .LEAD_BITS(3), .FRAME_BITS(16)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .pre_i(pre), .clr_ovr_i(clr),
        .adc_miso_i(adc_miso), .adc_sclk_o(adc_sclk), .adc_cs_n_o(adc_cs_n),
        .out_data_o(out_data), .ld_o(ld), .full_i(full), .overrun_o(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: bit r of the frame word is presented until the r-th SCLK rise.
    logic [4:0]  r = 5'd0;
    logic [15:0] fw;
    assign fw = {3'b101, adc_word, 3'b011};
    assign adc_miso = (r < 5'd16) ? fw[4'd15 - r[3:0]] : 1'b0;
    always @(posedge adc_sclk or posedge adc_cs_n) begin
        if (adc_cs_n) r <= 5'd0;
        else          r <= r + 5'd1;
    end

    always @(negedge clk) begin
        if (!adc_cs_n) cs_low_cnt <= cs_low_cnt + 1;
        if (!adc_cs_n && prev_cs) begin
            fall_prev <= fall_last;
            fall_last <= cyc;
        end
        if (adc_sclk && !prev_sclk) rise_cnt <= rise_cnt + 1;
        if (ld) begin
            ld_cnt <= ld_cnt + 1;
            ld_cyc <= cyc;
            ld_dat <= out_data;
        end
        prev_cs   <= adc_cs_n;
        prev_sclk <= adc_sclk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"},    int'(adc_cs_n), 1);
        chk({tag, "_sclk"},    int'(adc_sclk), 0);
        chk({tag, "_ld"},      int'(ld), 0);
        chk({tag, "_data"},    int'(out_data), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    int f1, e, g, rr;
    int s_ld, s_cs, s_rise;

    initial begin
        rst = 1'b1; en = 1'b0; pre = 10'd0; full = 1'b0; clr = 1'b0;
        adc_word = 10'h2A5;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef ADC_SAMPLER_AVG_EN
        s_ld = ld_cnt; s_cs = cs_low_cnt;
        adc_word = 10'h100;
        e = cyc; en = 1'b1; f1 = e + 1;
        wait_cyc(f1 + 100); adc_word = 10'h101;
        wait_cyc(f1 + 400); adc_word = 10'h102;
        wait_cyc(f1 + 700); adc_word = 10'h104;
        chk("avg_no_early_ld", ld_cnt - s_ld, 0);
        wait_cyc(f1 + 950);
        chk("avg_first_fall", fall_last - (f1 + 900), 0);
        chk("avg_ld_count", ld_cnt - s_ld, 1);
        chk("avg_ld_cycle", ld_cyc, f1 + 933);
        chk("avg_data", int'(ld_dat), 'h101);
        chk("avg_cs_low", cs_low_cnt - s_cs, 128);
        chk("avg_overrun", int'(overrun), 0);
`else
        // Single frame, H=1.
        s_ld = ld_cnt; s_cs = cs_low_cnt; s_rise = rise_cnt;
        e = cyc; en = 1'b1; f1 = e + 1;
        wait_cyc(f1 + 40);
        chk("first_fall", fall_last, f1);
        chk("f1_ld_count", ld_cnt - s_ld, 1);
        chk("f1_ld_cycle", ld_cyc, f1 + 33);
        chk("f1_data", int'(ld_dat), 'h2A5);
        chk("f1_cs_low", cs_low_cnt - s_cs, 32);
        chk("f1_sclk_rises", rise_cnt - s_rise, 16);

        // Periodic frames with H=4; pre is latched at the next frame start.
        pre = 10'd3; adc_word = 10'h15A;
        s_ld = ld_cnt; s_cs = cs_low_cnt; s_rise = rise_cnt;
        wait_cyc(f1 + 740);
        chk("per_ld_count", ld_cnt - s_ld, 2);
        chk("per_cs_low", cs_low_cnt - s_cs, 256);
        chk("per_sclk_rises", rise_cnt - s_rise, 32);
        chk("per_fall2", fall_prev, f1 + 300);
        chk("per_fall3", fall_last, f1 + 600);
        chk("per_data", int'(ld_dat), 'h15A);

        // Drop on full, clear, then set and clear together.
        full = 1'b1; s_ld = ld_cnt;
        wait_cyc(f1 + 1050);
        chk("full_no_ld", ld_cnt - s_ld, 0);
        chk("ovr_set", int'(overrun), 1);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        chk("ovr_clear", int'(overrun), 0);
        wait_cyc(f1 + 1328);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        chk("ovr_set_wins", int'(overrun), 1);
        chk("fall5", fall_last, f1 + 1200);
        full = 1'b0; pre = 10'd1;

        // Abort at frame cycle 10 while SCLK is high (H=2).
        wait_cyc(f1 + 1400); s_ld = ld_cnt;
        wait_cyc(f1 + 1510);
        chk("abort_pre_sclk", int'(adc_sclk), 1);
        chk("abort_pre_cs", int'(adc_cs_n), 0);
        en = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", int'(adc_cs_n), 1);
        chk("abort_sclk", int'(adc_sclk), 0);
        wait_cyc(f1 + 1600);
        chk("abort_no_ld", ld_cnt - s_ld, 0);

        adc_word = 10'h3C3;
        e = cyc; en = 1'b1;
        wait_cyc(e + 70);
        chk("reen_fall", fall_last, e + 1);
        chk("reen_ld_cycle", ld_cyc, e + 66);
        chk("reen_data", int'(ld_dat), 'h3C3);

        // Asynchronous reset between clock edges, mid-frame with SCLK high.
        g = e + 301;
        wait_cyc(g + 22);
        chk("rst_pre_sclk", int'(adc_sclk), 1);
        chk("rst_pre_cs", int'(adc_cs_n), 0);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk); @(negedge clk);
        rr = cyc; rst = 1'b0;
        wait_cyc(rr + 70);
        chk("post_rst_fall", fall_last, rr + 1);
        chk("post_rst_ld_cycle", ld_cyc, rr + 66);
        chk("post_rst_data", int'(ld_dat), 'h3C3);
        chk("post_rst_overrun", int'(overrun), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
